// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath (seconds counter, minute/hour
// counter, display stage).
//   state_e   : time-set FSM encoding, also driven out as set_state
//   SEC_MAX   : terminal seconds value (wrap marker)
//   MIN_MAX   : terminal minute value
//   HOUR_MAX  : terminal hour value (24-hour clock)
//   CLR_MASK  : cycles of wrap masking after a seconds clear
//   inc_wrap  : compare-then-wrap increment used by every counter field
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned CLR_MASK = 4;

  // Returns 0 once the value has reached the limit, so a field can never
  // step past its terminal count.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/min_hour_counter_if.sv
// Bundle between the minute/hour counter and its neighbours.
//   sec_ctr   : seconds value from the seconds counter (1 Hz domain)
//   btn_mode  : debounced mode button level
//   btn_inc   : debounced increment button level
//   min_ctr   : minutes 0..MIN_MAX
//   hour_ctr  : hours 0..HOUR_MAX
//   set_state : 00 RUN, 01 SET_HOUR, 10 SET_MIN
//   sec_clr   : one-cycle clear to the seconds counter
//   min_tick  : one-cycle pulse per wrap-driven minute advance
// master = the surroundings (drives seconds and buttons), slave = the counter.
interface min_hour_counter_if;
  logic [5:0] sec_ctr;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] min_ctr;
  logic [4:0] hour_ctr;
  logic [1:0] set_state;
  logic       sec_clr;
  logic       min_tick;

  modport master (
    output sec_ctr, btn_mode, btn_inc,
    input  min_ctr, hour_ctr, set_state, sec_clr, min_tick
  );

  modport slave (
    input  sec_ctr, btn_mode, btn_inc,
    output min_ctr, hour_ctr, set_state, sec_clr, min_tick
  );
endinterface

// File: rtl/min_hour_counter_rise_detect.sv
// Single-bit rising-edge detector for clk-synchronous button levels.
//   clk, reset : system clock, asynchronous active-high reset
//   level      : input level
//   rise       : high in the cycle where level is 1 and was 0 the cycle before
// History resets to 1 so a button held through reset release is not an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = level;
  end

  assign rise = level & ~hist_q;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= hist_d;
  end

endmodule

// File: rtl/min_hour_counter.sv
// Minute/hour stage of the clock, downstream of the seconds counter.
//   clk   : system clock (much faster than 1 Hz)
//   reset : asynchronous, active-high
//   bus   : min_hour_counter_if.slave (seconds in, buttons in, time/state out)
// Seconds are double-sampled and only accepted when two samples agree, so a
// mid-transition bus value is never seen. A stable 59 -> 0 advances minutes
// (and hours) in RUN. The set FSM lets btn_inc edit hours then minutes; on
// leaving SET_MIN a one-cycle sec_clr is issued and wrap detection is masked
// for CLR_MASK cycles so the forced 59 -> 0 does not count as a minute.
module min_hour_counter #(
  parameter int unsigned SEC_MAX  = clock_pkg::SEC_MAX,
  parameter int unsigned MIN_MAX  = clock_pkg::MIN_MAX,
  parameter int unsigned HOUR_MAX = clock_pkg::HOUR_MAX,
  parameter int unsigned CLR_MASK = clock_pkg::CLR_MASK
) (
  input logic               clk,
  input logic               reset,
  min_hour_counter_if.slave bus
);
  import clock_pkg::*;

  localparam int         MASK_W     = (CLR_MASK < 1) ? 1 : $clog2(CLR_MASK + 1);
  localparam logic [5:0] SEC_MAX_V  = 6'(SEC_MAX);
  localparam logic [5:0] MIN_MAX_V  = 6'(MIN_MAX);
  localparam logic [5:0] HOUR_MAX_V = 6'(HOUR_MAX);
  localparam logic [MASK_W-1:0] CLR_MASK_V = MASK_W'(CLR_MASK);

  logic [5:0]        s1_q, s1_d, s2_q, s2_d, stable_q, stable_d;
  logic [5:0]        min_q, min_d;
  logic [4:0]        hour_q, hour_d;
  state_e            state_q, state_d;
  logic              sec_clr_q, sec_clr_d;
  logic              min_tick_q, min_tick_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              mode_rise, inc_rise, wrap;

  rise_detect u_mode_rise (.clk(clk), .reset(reset), .level(bus.btn_mode), .rise(mode_rise));
  rise_detect u_inc_rise  (.clk(clk), .reset(reset), .level(bus.btn_inc),  .rise(inc_rise));

  // Wrap fires on the edge where sec_stable moves from SEC_MAX to 0.
  assign wrap = (stable_q == SEC_MAX_V) && (s1_q == s2_q) && (s1_q == 6'd0) &&
                (mask_q == '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s1_d       = bus.sec_ctr;
    s2_d       = s1_q;
    stable_d   = (s1_q == s2_q) ? s1_q : stable_q;
    min_d      = min_q;
    hour_d     = hour_q;
    state_d    = state_q;
    sec_clr_d  = 1'b0;
    min_tick_d = 1'b0;
    mask_d     = (mask_q != '0) ? mask_q - 1'b1 : '0;

    case (state_q)
      ST_RUN: begin
        // Wrap still applies on the same edge a mode press leaves RUN.
        if (wrap) begin
          min_tick_d = 1'b1;
          if (min_q >= MIN_MAX_V) begin
            min_d  = 6'd0;
            hour_d = 5'(inc_wrap({1'b0, hour_q}, HOUR_MAX_V));
          end else begin
            min_d = min_q + 6'd1;
          end
        end
        if (mode_rise) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (mode_rise)     state_d = ST_SET_MIN;
        else if (inc_rise) hour_d  = 5'(inc_wrap({1'b0, hour_q}, HOUR_MAX_V));
      end
      ST_SET_MIN: begin
        if (mode_rise) begin
          state_d   = ST_RUN;
          sec_clr_d = 1'b1;
          // Mask is live during the sec_clr cycle itself and counts down after.
          mask_d    = CLR_MASK_V;
        end else if (inc_rise) begin
          min_d = inc_wrap(min_q, MIN_MAX_V);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      state_q    <= ST_RUN;
      sec_clr_q  <= 1'b0;
      min_tick_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_q   <= stable_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      state_q    <= state_d;
      sec_clr_q  <= sec_clr_d;
      min_tick_q <= min_tick_d;
      mask_q     <= mask_d;
    end
  end

  assign bus.min_ctr   = min_q;
  assign bus.hour_ctr  = hour_q;
  assign bus.set_state = state_q;
  assign bus.sec_clr   = sec_clr_q;
  assign bus.min_tick  = min_tick_q;

endmodule

// File: tb/tb_min_hour_counter.sv
// Directed bench for min_hour_counter: reset, wrap latency, set mode,
// frozen time, exit clear with masking, 23:59 rollover, bus glitch,
// simultaneous events, and reset during set mode.
module tb_min_hour_counter;

  logic clk;
  logic reset;
  int   tests_run;
  int   fails;
  int   tick_cnt;
  int   clr_cnt;

  min_hour_counter_if bus ();

  min_hour_counter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.min_tick === 1'b1) tick_cnt <= tick_cnt + 1;
    if (bus.sec_clr === 1'b1)  clr_cnt  <= clr_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sec(input logic [5:0] v, input int hold);
    bus.sec_ctr = v;
    tick(hold);
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    tick(1);
    bus.btn_mode = 1'b0;
    tick(1);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_inc = 1'b1;
      tick(1);
      bus.btn_inc = 1'b0;
      tick(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    bus.btn_mode = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
    tests_run++;
    if (bus.set_state !== 2'b00) begin fails++; $display("FAIL reset_held_mode: state got %0d expected 0", bus.set_state); end
    tests_run++;
    if (bus.min_ctr !== 6'd0 || bus.hour_ctr !== 5'd0) begin fails++; $display("FAIL reset_time: got %0d:%0d expected 0:0", bus.hour_ctr, bus.min_ctr); end
    tests_run++;
    if (bus.sec_clr !== 1'b0 || bus.min_tick !== 1'b0) begin fails++; $display("FAIL reset_pulses: sec_clr %0b min_tick %0b expected 0 0", bus.sec_clr, bus.min_tick); end
    bus.btn_mode = 1'b0;
    tick(2);
  endtask

  task automatic test_wrap_latency();
    int t0;
    set_sec(6'd57, 8);
    set_sec(6'd58, 8);
    set_sec(6'd59, 8);
    t0 = tick_cnt;
    bus.sec_ctr = 6'd0;
    tick(2);
    tests_run++;
    if (bus.min_ctr !== 6'd0) begin fails++; $display("FAIL wrap_early: min got %0d expected 0", bus.min_ctr); end
    tick(1);
    tests_run++;
    if (bus.min_ctr !== 6'd1 || bus.min_tick !== 1'b1) begin fails++; $display("FAIL wrap_3rd_edge: min %0d tick %0b expected 1 1", bus.min_ctr, bus.min_tick); end
    tick(1);
    tests_run++;
    if (bus.min_tick !== 1'b0) begin fails++; $display("FAIL wrap_tick_width: tick got %0b expected 0", bus.min_tick); end
    tick(4);
    tests_run++;
    if (tick_cnt - t0 !== 1 || bus.hour_ctr !== 5'd0) begin fails++; $display("FAIL wrap_once: ticks %0d hour %0d expected 1 0", tick_cnt - t0, bus.hour_ctr); end
  endtask

  task automatic test_run_inc_ignored();
    press_inc(3);
    tests_run++;
    if (bus.min_ctr !== 6'd1 || bus.hour_ctr !== 5'd0 || bus.set_state !== 2'b00) begin
      fails++; $display("FAIL run_inc: got %0d:%0d state %0d expected 0:1 state 0", bus.hour_ctr, bus.min_ctr, bus.set_state);
    end
  endtask

  task automatic test_glitch();
    int t0;
    set_sec(6'd59, 8);
    t0 = tick_cnt;
    set_sec(6'd63, 1);
    set_sec(6'd0, 8);
    tests_run++;
    if (bus.min_ctr !== 6'd2 || tick_cnt - t0 !== 1) begin fails++; $display("FAIL glitch: min %0d ticks %0d expected 2 1", bus.min_ctr, tick_cnt - t0); end
  endtask

  task automatic test_simultaneous();
    set_sec(6'd59, 8);
    bus.sec_ctr = 6'd0;
    tick(2);
    bus.btn_mode = 1'b1;
    tick(1);
    tests_run++;
    if (bus.set_state !== 2'b01 || bus.min_ctr !== 6'd3 || bus.min_tick !== 1'b1) begin
      fails++; $display("FAIL wrap_with_mode: state %0d min %0d tick %0b expected 1 3 1", bus.set_state, bus.min_ctr, bus.min_tick);
    end
    bus.btn_mode = 1'b0;
    tick(1);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    tick(1);
    tests_run++;
    if (bus.set_state !== 2'b10 || bus.hour_ctr !== 5'd0) begin fails++; $display("FAIL mode_beats_inc: state %0d hour %0d expected 2 0", bus.set_state, bus.hour_ctr); end
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick(1);
    press_mode();
    tick(10);
    tests_run++;
    if (bus.set_state !== 2'b00 || bus.min_ctr !== 6'd3) begin fails++; $display("FAIL back_to_run: state %0d min %0d expected 0 3", bus.set_state, bus.min_ctr); end
  endtask

  task automatic test_set_fields();
    do_reset();
    press_mode();
    press_inc(25);
    tests_run++;
    if (bus.hour_ctr !== 5'd1 || bus.set_state !== 2'b01) begin fails++; $display("FAIL set_hour: hour %0d state %0d expected 1 1", bus.hour_ctr, bus.set_state); end
    press_mode();
    press_inc(61);
    tests_run++;
    if (bus.min_ctr !== 6'd1 || bus.hour_ctr !== 5'd1 || bus.set_state !== 2'b10) begin
      fails++; $display("FAIL set_min: got %0d:%0d state %0d expected 1:1 state 2", bus.hour_ctr, bus.min_ctr, bus.set_state);
    end
  endtask

  task automatic test_set_frozen();
    int t0;
    t0 = tick_cnt;
    set_sec(6'd58, 8);
    set_sec(6'd59, 8);
    set_sec(6'd0, 8);
    tests_run++;
    if (bus.min_ctr !== 6'd1 || tick_cnt - t0 !== 0) begin fails++; $display("FAIL set_frozen: min %0d ticks %0d expected 1 0", bus.min_ctr, tick_cnt - t0); end
  endtask

  task automatic test_exit_clear();
    int t0, c0;
    set_sec(6'd59, 8);
    t0 = tick_cnt;
    c0 = clr_cnt;
    bus.btn_mode = 1'b1;
    tick(1);
    tests_run++;
    if (bus.set_state !== 2'b00 || bus.sec_clr !== 1'b1) begin fails++; $display("FAIL exit_clr: state %0d sec_clr %0b expected 0 1", bus.set_state, bus.sec_clr); end
    bus.sec_ctr  = 6'd0;
    bus.btn_mode = 1'b0;
    tick(1);
    tests_run++;
    if (bus.sec_clr !== 1'b0) begin fails++; $display("FAIL exit_clr_width: sec_clr got %0b expected 0", bus.sec_clr); end
    tick(10);
    tests_run++;
    if (bus.min_ctr !== 6'd1 || bus.hour_ctr !== 5'd1 || tick_cnt - t0 !== 0 || clr_cnt - c0 !== 1) begin
      fails++; $display("FAIL exit_mask: %0d:%0d ticks %0d clrs %0d expected 1:1 0 1", bus.hour_ctr, bus.min_ctr, tick_cnt - t0, clr_cnt - c0);
    end
  endtask

  task automatic test_rollover_2359();
    int t0, c0;
    do_reset();
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(59);
    tests_run++;
    if (bus.hour_ctr !== 5'd23 || bus.min_ctr !== 6'd59) begin fails++; $display("FAIL preload: got %0d:%0d expected 23:59", bus.hour_ctr, bus.min_ctr); end
    c0 = clr_cnt;
    press_mode();
    tick(10);
    tests_run++;
    if (clr_cnt - c0 !== 1 || bus.set_state !== 2'b00) begin fails++; $display("FAIL preload_exit: clrs %0d state %0d expected 1 0", clr_cnt - c0, bus.set_state); end
    t0 = tick_cnt;
    set_sec(6'd59, 8);
    set_sec(6'd0, 5);
    tests_run++;
    if (bus.hour_ctr !== 5'd0 || bus.min_ctr !== 6'd0 || tick_cnt - t0 !== 1) begin
      fails++; $display("FAIL rollover: %0d:%0d ticks %0d expected 0:0 1", bus.hour_ctr, bus.min_ctr, tick_cnt - t0);
    end
  endtask

  task automatic test_reset_mid_set();
    int c0;
    press_mode();
    press_inc(5);
    tests_run++;
    if (bus.hour_ctr !== 5'd5 || bus.set_state !== 2'b01) begin fails++; $display("FAIL mid_set_setup: hour %0d state %0d expected 5 1", bus.hour_ctr, bus.set_state); end
    c0 = clr_cnt;
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.hour_ctr !== 5'd0 || bus.min_ctr !== 6'd0 || bus.set_state !== 2'b00 || bus.sec_clr !== 1'b0) begin
      fails++; $display("FAIL async_reset: %0d:%0d state %0d sec_clr %0b expected 0:0 0 0", bus.hour_ctr, bus.min_ctr, bus.set_state, bus.sec_clr);
    end
    tick(3);
    reset = 1'b0;
    tick(3);
    tests_run++;
    if (clr_cnt - c0 !== 0 || bus.set_state !== 2'b00) begin fails++; $display("FAIL reset_no_clr: clrs %0d state %0d expected 0 0", clr_cnt - c0, bus.set_state); end
  endtask

  initial begin
    tests_run    = 0;
    fails        = 0;
    tick_cnt     = 0;
    clr_cnt      = 0;
    reset        = 1'b1;
    bus.sec_ctr  = 6'd0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick(1);

    test_reset();
    test_wrap_latency();
    test_run_inc_ignored();
    test_glitch();
    test_simultaneous();
    test_set_fields();
    test_set_frozen();
    test_exit_clear();
    test_rollover_2359();
    test_reset_mid_set();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
